// File: rtl/iu_pkg.sv
// Shared types and constants for the integer-unit hazard scoreboard.
package iu_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 8;
    localparam int FWD_RF    = 0;
    localparam int RN_W      = 8;
    localparam int LAT_W     = 4;

    typedef struct packed {
        logic             v;
        logic [RN_W-1:0]  rn;
        logic [LAT_W-1:0] lat;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{v: 1'b0, rn: 8'd0, lat: 4'd0};

    // A latency of zero would mean "ready before EXE", which cannot exist.
    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        return (lat == 4'd0) ? 4'd1 : lat;
    endfunction

endpackage

// File: rtl/iu_sb_match.sv
// Per-source priority match over the in-flight entries; youngest stage wins.
module iu_sb_match
    import iu_pkg::*;
#(
    parameter int NE  = 2,
    parameter int RA  = 5,
    parameter int SWP = 3
) (
    input  sb_entry_t [NE-1:0] entries,
    input  logic [RA-1:0]      src,
    input  logic               use_src,
    output logic               hit,
    output logic               ready,
    output logic [SWP-1:0]     stage
);

    // Scan oldest to youngest so the youngest match is the last assignment.
    always_comb begin
        hit   = 1'b0;
        ready = 1'b0;
        stage = {SWP{1'b0}};
        for (int k = NE; k >= 1; k--) begin
            if (use_src && (src != {RA{1'b0}}) && entries[k-1].v &&
                (entries[k-1].rn == RN_W'(src))) begin
                hit   = 1'b1;
                ready = (LAT_W'(k) >= entries[k-1].lat);
                stage = SWP'(k);
            end else begin
                hit   = hit;
            end
        end
    end

endmodule

// File: rtl/iu_hazard_scoreboard.sv
// Register-hazard scoreboard and ID operand forwarding; define IU_SB_FWD_EN
// to enable forwarding, otherwise any in-flight match interlocks.
module iu_hazard_scoreboard
    import iu_pkg::*;
#(
    parameter int DW    = 32,
    parameter int NREG  = 32,
    parameter int DEPTH = 3,
    localparam int RA   = $clog2(NREG),
    localparam int SW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic                id_valid,
    input  logic [RA-1:0]       id_rs,
    input  logic [RA-1:0]       id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_wreg,
    input  logic [RA-1:0]       id_rn,
    input  logic [SW:0]         id_lat,
    input  logic                ext_stall,
    input  logic [DW-1:0]       rf_a,
    input  logic [DW-1:0]       rf_b,
    input  logic [DEPTH*DW-1:0] stage_data,
    output logic                stall,
    output logic [SW:0]         fwd_a,
    output logic [SW:0]         fwd_b,
    output logic [DW-1:0]       da,
    output logic [DW-1:0]       db,
    output logic [15:0]         stall_cnt
);

    localparam int NE  = DEPTH - 1;
    localparam int SWP = SW + 1;
`ifdef IU_SB_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    sb_entry_t [NE-1:0] entries_r;
    sb_entry_t          new_entry_s;
    logic               hit_a_s, hit_b_s, ready_a_s, ready_b_s;
    logic [SWP-1:0]     stage_a_s, stage_b_s, fwd_a_s, fwd_b_s;
    logic               stall_s;
    logic [15:0]        stall_cnt_r;

    iu_sb_match #(.NE(NE), .RA(RA), .SWP(SWP)) u_match_rs (
        .entries(entries_r), .src(id_rs), .use_src(id_use_rs),
        .hit(hit_a_s), .ready(ready_a_s), .stage(stage_a_s)
    );

    iu_sb_match #(.NE(NE), .RA(RA), .SWP(SWP)) u_match_rt (
        .entries(entries_r), .src(id_rt), .use_src(id_use_rt),
        .hit(hit_b_s), .ready(ready_b_s), .stage(stage_b_s)
    );

    // Without forwarding a ready result is still unusable, so every hit stalls.
    assign stall_s = id_valid & ((hit_a_s & ~(FWD_EN & ready_a_s)) |
                                 (hit_b_s & ~(FWD_EN & ready_b_s)));
    assign fwd_a_s = (FWD_EN & hit_a_s & ready_a_s) ? stage_a_s : SWP'(FWD_RF);
    assign fwd_b_s = (FWD_EN & hit_b_s & ready_b_s) ? stage_b_s : SWP'(FWD_RF);

    // Operand muxes: register file unless a tracked stage is selected.
    always_comb begin
        da = rf_a;
        db = rf_b;
        for (int k = 1; k <= NE; k++) begin
            if (fwd_a_s == SWP'(k)) begin
                da = stage_data[k*DW-1 -: DW];
            end else begin
                da = da;
            end
            if (fwd_b_s == SWP'(k)) begin
                db = stage_data[k*DW-1 -: DW];
            end else begin
                db = db;
            end
        end
    end

    // Entry 1 takes the issuing writer, or a bubble when ID does not advance.
    always_comb begin
        new_entry_s = SB_EMPTY;
        if (id_valid && !stall_s && !ext_stall) begin
            new_entry_s = '{v:   id_wreg & (id_rn != {RA{1'b0}}),
                            rn:  RN_W'(id_rn),
                            lat: clamp_lat(LAT_W'(id_lat))};
        end else begin
            new_entry_s = SB_EMPTY;
        end
    end

    // Pipeline shift of tracked entries and saturating stall counter.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            entries_r   <= {NE{SB_EMPTY}};
            stall_cnt_r <= 16'd0;
        end else begin
            entries_r[0] <= new_entry_s;
            for (int k = 1; k < NE; k++) begin
                entries_r[k] <= entries_r[k-1];
            end
            if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign stall     = stall_s;
    assign fwd_a     = fwd_a_s;
    assign fwd_b     = fwd_b_s;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_iu_hazard_scoreboard.sv
// Directed bench for iu_hazard_scoreboard (DEPTH=3); expectations follow IU_SB_FWD_EN.
module tb_iu_hazard_scoreboard;

    localparam int DW = 32;
`ifdef IU_SB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [31:0] S1  = 32'h1111_1111;
    localparam logic [31:0] S2  = 32'h2222_2222;
    localparam logic [31:0] S3  = 32'h3333_3333;
    localparam logic [31:0] RFA = 32'hAAAA_0000;
    localparam logic [31:0] RFB = 32'hBBBB_0000;

    logic        clk = 1'b0;
    logic        clrn;
    logic        id_valid, id_use_rs, id_use_rt, id_wreg, ext_stall;
    logic [4:0]  id_rs, id_rt, id_rn;
    logic [2:0]  id_lat;
    logic [31:0] rf_a, rf_b;
    logic [95:0] stage_data;
    logic        stall;
    logic [2:0]  fwd_a, fwd_b;
    logic [31:0] da, db;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    iu_hazard_scoreboard #(.DW(DW), .NREG(32), .DEPTH(3)) dut (
        .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_rn(id_rn),
        .id_lat(id_lat), .ext_stall(ext_stall), .rf_a(rf_a), .rf_b(rf_b),
        .stage_data(stage_data), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .da(da), .db(db), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic w,
                          input logic [4:0] rn, input logic [2:0] lat);
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_wreg = w; id_rn = rn; id_lat = lat;
        #1;
    endtask

    task automatic do_reset();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0);
        ext_stall = 1'b0;
        clrn = 1'b0;
        #3;
        clrn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 3'd1);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b exp 0", stall); end
        tests++; if (fwd_a !== 3'd0) begin fails++; $display("FAIL reset_fwd_a: got %0d exp 0", fwd_a); end
        tests++; if (fwd_b !== 3'd0) begin fails++; $display("FAIL reset_fwd_b: got %0d exp 0", fwd_b); end
        tests++; if (da !== RFA) begin fails++; $display("FAIL reset_da: got %h exp %h", da, RFA); end
        tests++; if (db !== RFB) begin fails++; $display("FAIL reset_db: got %h exp %h", db, RFB); end
        tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d exp 0", stall_cnt); end
        clrn = 1'b1;
    endtask

    task automatic test_alu_fwd();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 3'd1);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL alu_issue_stall: got %0b exp 0", stall); end
        step();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd1);
        tests++; if (stall !== !FWD) begin fails++; $display("FAIL alu_c1_stall: got %0b exp %0b", stall, !FWD); end
        tests++; if (fwd_a !== (FWD ? 3'd1 : 3'd0)) begin fails++; $display("FAIL alu_c1_fwd_a: got %0d exp %0d", fwd_a, FWD ? 1 : 0); end
        tests++; if (da !== (FWD ? S1 : RFA)) begin fails++; $display("FAIL alu_c1_da: got %h exp %h", da, FWD ? S1 : RFA); end
        step();
        tests++; if (stall !== !FWD) begin fails++; $display("FAIL alu_c2_stall: got %0b exp %0b", stall, !FWD); end
        tests++; if (fwd_a !== (FWD ? 3'd2 : 3'd0)) begin fails++; $display("FAIL alu_c2_fwd_a: got %0d exp %0d", fwd_a, FWD ? 2 : 0); end
        tests++; if (da !== (FWD ? S2 : RFA)) begin fails++; $display("FAIL alu_c2_da: got %h exp %h", da, FWD ? S2 : RFA); end
        step();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL alu_c3_stall: got %0b exp 0", stall); end
        tests++; if (fwd_a !== 3'd0) begin fails++; $display("FAIL alu_c3_fwd_a: got %0d exp 0", fwd_a); end
        tests++; if (da !== RFA) begin fails++; $display("FAIL alu_c3_da: got %h exp %h", da, RFA); end
        tests++; if (stall_cnt !== (FWD ? 16'd0 : 16'd2)) begin fails++; $display("FAIL alu_cnt: got %0d exp %0d", stall_cnt, FWD ? 0 : 2); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 3'd2);
        step();
        set_id(1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 3'd1);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL load_c1_stall: got %0b exp 1", stall); end
        tests++; if (fwd_b !== 3'd0) begin fails++; $display("FAIL load_c1_fwd_b: got %0d exp 0", fwd_b); end
        step();
        tests++; if (stall !== !FWD) begin fails++; $display("FAIL load_c2_stall: got %0b exp %0b", stall, !FWD); end
        tests++; if (fwd_b !== (FWD ? 3'd2 : 3'd0)) begin fails++; $display("FAIL load_c2_fwd_b: got %0d exp %0d", fwd_b, FWD ? 2 : 0); end
        tests++; if (db !== (FWD ? S2 : RFB)) begin fails++; $display("FAIL load_c2_db: got %h exp %h", db, FWD ? S2 : RFB); end
        tests++; if (stall_cnt !== 16'd1) begin fails++; $display("FAIL load_c2_cnt: got %0d exp 1", stall_cnt); end
        step();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL load_c3_stall: got %0b exp 0", stall); end
        tests++; if (stall_cnt !== (FWD ? 16'd1 : 16'd2)) begin fails++; $display("FAIL load_c3_cnt: got %0d exp %0d", stall_cnt, FWD ? 1 : 2); end
    endtask

    task automatic test_youngest_and_zero();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 3'd1);
        step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 3'd1);
        step();
        set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 3'd1);
        tests++; if (stall !== !FWD) begin fails++; $display("FAIL young_stall: got %0b exp %0b", stall, !FWD); end
        tests++; if (fwd_a !== (FWD ? 3'd1 : 3'd0)) begin fails++; $display("FAIL young_fwd_a: got %0d exp %0d", fwd_a, FWD ? 1 : 0); end
        tests++; if (da !== (FWD ? S1 : RFA)) begin fails++; $display("FAIL young_da: got %h exp %h", da, FWD ? S1 : RFA); end
        tests++; if (fwd_b !== (FWD ? 3'd1 : 3'd0)) begin fails++; $display("FAIL same_reg_fwd_b: got %0d exp %0d", fwd_b, FWD ? 1 : 0); end
        tests++; if (db !== (FWD ? S1 : RFB)) begin fails++; $display("FAIL same_reg_db: got %h exp %h", db, FWD ? S1 : RFB); end
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 3'd2);
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 3'd1);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL zero_stall: got %0b exp 0", stall); end
        tests++; if (fwd_a !== 3'd0) begin fails++; $display("FAIL zero_fwd_a: got %0d exp 0", fwd_a); end
        tests++; if (fwd_b !== 3'd0) begin fails++; $display("FAIL zero_fwd_b: got %0d exp 0", fwd_b); end
    endtask

    task automatic test_ext_stall();
        do_reset();
        ext_stall = 1'b1;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 3'd2);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL ext_no_fold: got %0b exp 0", stall); end
        step();
        step();
        ext_stall = 1'b0;
        set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 3'd1);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL ext_after_stall: got %0b exp 0", stall); end
        tests++; if (fwd_a !== 3'd0) begin fails++; $display("FAIL ext_after_fwd_a: got %0d exp 0", fwd_a); end
        tests++; if (da !== RFA) begin fails++; $display("FAIL ext_after_da: got %h exp %h", da, RFA); end
        tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL ext_cnt: got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 3'd2);
        step();
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd1);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL mid_pre_stall: got %0b exp 1", stall); end
        clrn = 1'b0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mid_async_stall: got %0b exp 0", stall); end
        #1;
        clrn = 1'b1;
        step();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mid_post_stall: got %0b exp 0", stall); end
        tests++; if (fwd_a !== 3'd0) begin fails++; $display("FAIL mid_post_fwd_a: got %0d exp 0", fwd_a); end
        tests++; if (da !== RFA) begin fails++; $display("FAIL mid_post_da: got %h exp %h", da, RFA); end
        tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL mid_post_cnt: got %0d exp 0", stall_cnt); end
    endtask

    initial begin
        rf_a = RFA;
        rf_b = RFB;
        stage_data = {S3, S2, S1};
        ext_stall = 1'b0;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest_and_zero();
        test_ext_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iu_hazard_scoreboard.md
# iu_hazard_scoreboard

Parametrised register-hazard scoreboard and operand-forwarding unit for the pipelined integer unit. It tracks every in-flight register-writing instruction across a configurable number of post-decode stages, forwards results to the ID-stage operands, and raises a stall when a needed result is not yet produced. It generalises the fixed E/M/W forwarding and load-use interlock to arbitrary pipeline depth, per-instruction result latency, and register count. It sits between the register file read ports and the ID/EXE pipeline registers.

## Interface
- DW, 32, datapath width
- NREG, 32, architectural register count; RA = $clog2(NREG); register 0 never creates a hazard
- DEPTH, 3, post-decode stages tracked (stage 1 = EXE … stage DEPTH = WB); legal range 2..8
- SW, $clog2(DEPTH), forward-select width
- clk  in  1  pipeline clock; one clock domain; all state updates on posedge clk
- clrn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RA  source register numbers
- id_use_rs, id_use_rt  in  1  the instruction reads that source
- id_wreg  in  1  the instruction writes a register
- id_rn  in  RA  destination register
- id_lat  in  SW+1  stage index at which the result becomes valid (1..DEPTH-1; 0 is treated as 1)
- ext_stall  in  1  external stall request (FPU, memory)
- rf_a, rf_b  in  DW  register-file read data
- stage_data  in  DEPTH*DW  result of stage k in bits [k*DW-1:(k-1)*DW]
- stall  out  1  ID must hold; bubble is inserted
- fwd_a, fwd_b  out  SW+1  0 = register file, k = stage k
- da, db  out  DW  forwarded operands
- stall_cnt  out  16  saturating count of cycles with stall asserted

## Operation
- State: DEPTH-1 entries {v, rn, lat}, entry k describing the instruction in stage k (k = 1..DEPTH-1); stage DEPTH is not tracked because the register file writes on the falling edge and ID reads the written value in the same cycle.
- Match for source s: entry k with v=1, rn==s, s!=0, and the corresponding id_use bit set. The youngest match (lowest k) wins.
- Winning entry ready iff k >= lat: fwd = k, operand = stage k data. Not ready: stall=1, fwd=0.
- No match: fwd=0, operand = rf_a/rf_b.
- stall = id_valid & (hazard on rs | hazard on rt). ext_stall is not folded into stall.
- Each posedge: entries shift k→k+1 and entry DEPTH-1 retires.
  - Entry 1 loads {id_wreg & (id_rn!=0), id_rn, max(id_lat,1)} when id_valid & ~stall & ~ext_stall.
  - Otherwise entry 1 loads a bubble (v=0).
- stall_cnt increments on each cycle with stall=1 and saturates at 16'hFFFF.

## Timing
- Reset: all entries v=0, rn=0, lat=0; stall_cnt=0. Outputs then read stall=0, fwd_a=fwd_b=0, da=rf_a, db=rf_b.
- stall, fwd_*, da and db are combinational from current state and ID inputs, valid in the same cycle.
- Issue-to-tracking latency is one cycle. An entry with lat L stalls a dependent ID for (L-1) cycles when the dependent is issued immediately behind it.
- Simultaneous hazards on rs and rt: a single stall; each source resolves independently.
- Same register as both rs and rt: both selects are identical.
- Reset asserted mid-operation clears all entries asynchronously; no stale forwarding after release.

## Configuration
- IU_SB_FWD_EN defined: forwarding as described above.
- IU_SB_FWD_EN undefined: fwd_a=fwd_b=0 always. Any valid match in stages 1..DEPTH-1 stalls regardless of lat, and operands always come from rf_a/rf_b (interlock-only pipeline).

## Structure
- Shared package iu_pkg: sb_entry_t struct {v, rn, lat}, the forward-select encoding constant FWD_RF=0, and the DEPTH limit constants.
- One sub-module, iu_sb_match: per-source priority match across the entries, returning {hit, ready, stage}. It is instantiated twice (rs, rt).

## Test plan
- Reset with clrn=0 mid-stream, after a load issue: entries clear; next cycle stall=0, fwd_a=0, da=rf_a.
- DEPTH=3: issue ALU op $5 with lat=1, then next cycle rs=$5: stall=0, fwd_a=1, da=stage_data[31:0].
- Load $8 with lat=2, then rt=$8 immediately: stall=1 for exactly one cycle. Next cycle fwd_b=2, db=stage 2 data; stall_cnt=1.
- Two writers of $3 at stages 1 and 2, both ready: fwd_a=1 (youngest wins). Any source $0 with a $0 writer in flight: fwd=0 and no stall.
- ext_stall=1 for 2 cycles with a writer in ID: the entry is not inserted and bubbles shift in; no false hazard occurs afterwards.
- IU_SB_FWD_EN undefined: ALU $5 with lat=1, then a reader of $5: stall=1 for 2 cycles (DEPTH-1), then da=rf_a with fwd_a=0.
